// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: saturation, Z/V/N flag update and a 2-entry
// FIFO skid buffer with valid/ready toward the memory stage.
module ex_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_ovfl,
  input  logic             in_a_msb,
  input  logic             in_sat,
  input  logic             in_wr_flags,
  input  logic [3:0]       in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_dst,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] sum,
                                                  input logic ovfl,
                                                  input logic a_msb,
                                                  input logic sat);
    logic [WIDTH-1:0] r;
    r = sum;
    if (sat && ovfl) begin
      r = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [3:0]       dst0_q, dst0_d, dst1_q, dst1_d;
  logic             z_q, z_d, v_q, v_d, n_q, n_d;
  logic [WIDTH-1:0] res_new;
  logic             push, pop;

  assign res_new    = sat_result(in_sum, in_ovfl, in_a_msb, in_sat);
  // in_ready decodes registered count only, so no path from out_ready
  assign in_ready   = (cnt_q != 2'(DEPTH));
  assign out_valid  = (cnt_q != 2'd0);
  assign out_result = res0_q;
  assign out_dst    = dst0_q;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign flag_n     = n_q;
  assign push       = in_valid & in_ready & ~flush;
  assign pop        = out_valid & out_ready & ~flush;

  always_comb begin
    cnt_d  = cnt_q;
    res0_d = res0_q;
    dst0_d = dst0_q;
    res1_d = res1_q;
    dst1_d = dst1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            res0_d = res_new;
            dst0_d = in_dst;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            res0_d = res_new;
            dst0_d = in_dst;
          end else if (push) begin
            res1_d = res_new;
            dst1_d = in_dst;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            res0_d = res1_q;
            dst0_d = dst1_q;
            cnt_d  = 2'd1;
          end
        end
      endcase
    end
  end

  // Flags follow the post-saturation result; V reports raw overflow
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (push && in_wr_flags) begin
      z_d = (res_new == '0);
      v_d = in_ovfl;
      n_d = res_new[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      res0_q <= '0;
      dst0_q <= 4'd0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      res0_q <= res0_d;
      dst0_q <= dst0_d;
      z_q    <= z_d;
      v_q    <= v_d;
      n_q    <= n_d;
    end
  end

  // Second slot is never observable unless count says so; no reset needed
  always_ff @(posedge clk) begin
    res1_q <= res1_d;
    dst1_q <= dst1_d;
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: directed vectors push expected
// entries; a negedge monitor pops and compares on each handshake.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [15:0] in_sum;
  logic        in_ovfl, in_a_msb, in_sat, in_wr_flags;
  logic [3:0]  in_dst;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        flag_z, flag_v, flag_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  ex_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_ovfl(in_ovfl), .in_a_msb(in_a_msb), .in_sat(in_sat),
    .in_wr_flags(in_wr_flags), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic z, input logic v, input logic n);
    chk(name, {17'd0, flag_z, flag_v, flag_n}, {17'd0, z, v, n});
  endtask

  // Drive one entry and hold it until accepted (bounded).
  task automatic send(input logic [15:0] sum, input logic ovfl, input logic amsb,
                      input logic sat, input logic wrf, input logic [3:0] dst,
                      input logic [15:0] exp);
    bit done;
    done        = 1'b0;
    in_valid    = 1'b1;
    in_sum      = sum;
    in_ovfl     = ovfl;
    in_a_msb    = amsb;
    in_sat      = sat;
    in_wr_flags = wrf;
    in_dst      = dst;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        sb.push_back({exp, dst});
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for dst %0d", dst);
    end
  endtask

  // Monitor: a handshake at negedge means the head leaves at the next edge.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h/%0d with empty scoreboard", out_result, out_dst);
      end else begin
        chk("pop_entry", {out_result, out_dst}, sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sum = '0; in_ovfl = 1'b0;
    in_a_msb = 1'b0; in_sat = 1'b0; in_wr_flags = 1'b0; in_dst = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", {19'd0, out_valid}, 20'd0);
    chk("reset_out", {out_result, out_dst}, 20'd0);
    chk_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    chk("reset_in_ready", {19'd0, in_ready}, 20'd1);

    // Single add, then saturation variants
    out_ready = 1'b1;
    send(16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0005);
    chk("lat1_out_valid", {19'd0, out_valid}, 20'd1);
    chk("lat1_out", {out_result, out_dst}, {16'h0005, 4'd1});
    chk_flags("add_flags", 1'b0, 1'b0, 1'b0);
    send(16'h8001, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h7FFF);
    chk_flags("sat_pos_flags", 1'b0, 1'b1, 1'b0);
    send(16'h7FFE, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 16'h8000);
    chk_flags("sat_neg_flags", 1'b0, 1'b1, 1'b1);
    send(16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'h8001);
    chk_flags("nosat_flags", 1'b0, 1'b1, 1'b1);
    send(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0000);
    chk_flags("zero_flags", 1'b1, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 16'hFFFF);
    chk_flags("masked_flags", 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk("drain1_empty", 20'(sb.size()), 20'd0);

    // Back-pressure: two accepted, third held until a pop frees a slot
    out_ready = 1'b0;
    send(16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0101);
    send(16'h0202, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0202);
    in_valid = 1'b1; in_sum = 16'h0303; in_dst = 4'd3; in_wr_flags = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("full_in_ready", {19'd0, in_ready}, 20'd0);
      chk("stall_stable", {out_result, out_dst}, {16'h0101, 4'd1});
      step();
    end
    out_ready = 1'b1;
    send(16'h0303, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0303);
    repeat (4) step();
    chk("drain2_empty", 20'(sb.size()), 20'd0);
    chk("drain2_out_valid", {19'd0, out_valid}, 20'd0);

    // Flush with one entry and an acceptable same-cycle input
    out_ready = 1'b0;
    send(16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0001);
    in_valid = 1'b1; in_sum = 16'h8000; in_ovfl = 1'b1; in_wr_flags = 1'b1; in_dst = 4'd9;
    flush = 1'b1; out_ready = 1'b1; sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0; in_ovfl = 1'b0;
    chk("flush1_out_valid", {19'd0, out_valid}, 20'd0);
    chk_flags("flush1_flags", 1'b0, 1'b0, 1'b0);

    // Flush with full buffer plus a same-cycle valid input
    out_ready = 1'b0;
    send(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h1234);
    send(16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h4321);
    in_valid = 1'b1; in_sum = 16'h0000; in_wr_flags = 1'b1; in_dst = 4'd8;
    flush = 1'b1; out_ready = 1'b1; sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", {19'd0, out_valid}, 20'd0);
    chk("flush2_in_ready", {19'd0, in_ready}, 20'd1);
    chk_flags("flush2_flags", 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // Reset mid-stream with a full, stalled buffer
    out_ready = 1'b0;
    send(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'hFFFF);
    send(16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 16'h00AA);
    chk_flags("pre_reset_flags", 1'b0, 1'b1, 1'b1);
    rst = 1'b1; sb.delete();
    step();
    chk("rst2_out_valid", {19'd0, out_valid}, 20'd0);
    chk("rst2_out", {out_result, out_dst}, 20'd0);
    chk_flags("rst2_flags", 1'b0, 1'b0, 1'b0);
    chk("rst2_in_ready", {19'd0, in_ready}, 20'd1);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", 20'(sb.size()), 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage result buffer that sits directly downstream of the 16-bit add/sub datapath. It captures the raw sum and overflow bit and applies optional saturation. It updates the architectural Z/V/N flag register, then holds results in a 2-entry skid buffer with a valid/ready handshake toward the memory stage. This decouples the combinational adder from back-pressure downstream and gives a flush path for branch mispredicts.

## Interface
- WIDTH, 16, datapath width; the block is only verified at 16
- DEPTH, 2, buffer entries; fixed at 2

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered entries and any same-cycle input
- in_valid  input  1  upstream adder result present
- in_ready  output  1  stage can accept an entry this cycle
- in_sum  input  16  raw sum/difference from adder
- in_ovfl  input  1  signed overflow from adder
- in_a_msb  input  1  sign bit of operand A; selects saturation direction
- in_sat  input  1  saturate on overflow
- in_wr_flags  input  1  update Z/V/N on acceptance
- in_dst  input  4  destination register tag, passed through
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_result  output  16  head entry result
- out_dst  output  4  head entry tag
- flag_z, flag_v, flag_n  output  1 each  architectural flags

## Operation
- Result: if in_sat & in_ovfl then (in_a_msb ? 16'h8000 : 16'h7FFF), else in_sum.
- Flags are computed from the final (post-saturation) result: Z = (result == 0), N = result[15], V = in_ovfl. Overflow is reported even when the result was saturated.
- Accept = in_valid & in_ready & ~flush. On accept, the entry {result, dst} is written to the tail. If in_wr_flags is set, the flags register is also loaded.
- Pop = out_valid & out_ready & ~flush. It removes the head.
- in_ready = (count != 2). It is a function of registered count only, with no combinational path from out_ready. When count == 2, an upstream entry is not taken even if a pop occurs that cycle.
- Count 0: out_valid = 0. Push only goes to count 1.
- Count 1: push with pop keeps count 1. The new entry becomes head next cycle. Push alone goes to 2. Pop alone goes to 0.
- Count 2: pop only goes to 1, and the second entry moves to head.
- Ordering is strict FIFO. out_result and out_dst must be stable while out_valid & ~out_ready.
- Flush has priority over push and pop. Next cycle count = 0. A same-cycle input is dropped and its flags are not written. Flags already written by earlier accepts are kept.
- Reset: count 0, out_valid 0, out_result 16'h0000, out_dst 0, flag_z/v/n 0. Reset overrides flush and handshakes. After reset deasserts, in_ready is 1 on the next cycle.

## Timing
- Latency is 1 cycle: an entry accepted at edge k is visible on out_valid/out_result after edge k if the buffer was empty.
- Flags are visible the cycle after accept, regardless of whether the entry has drained.
- Throughput is 1 entry/cycle while out_ready stays high.
- in_ready drops the cycle after count reaches 2. It rises the cycle after the first pop from full.
- Outputs are registered: out_valid, out_result, out_dst, in_ready and the flags come straight from flops or count decode.

## Test plan
- Reset then single add: in_sum=16'h0005, in_ovfl=0, in_wr_flags=1, out_ready=1 -> next cycle out_valid=1, out_result=16'h0005; flags Z=0, N=0, V=0.
- Saturation: in_sum=16'h8001, in_ovfl=1, in_a_msb=0, in_sat=1 -> out_result=16'h7FFF, V=1, N=0. Same with in_a_msb=1, in_sum=16'h7FFE -> 16'h8000, N=1. With in_sat=0 -> raw in_sum passes through.
- Back-pressure: out_ready=0 and three consecutive in_valid -> first two accepted, in_ready=0 while full, third held. Raise out_ready -> outputs drain in order with tags 1, 2, 3 and none lost or duplicated.
- Zero/flag mask: result 16'h0000 with in_wr_flags=1 -> Z=1. Next entry 16'hFFFF with in_wr_flags=0 -> flags unchanged (Z=1, N=0).
- Flush with full buffer plus a same-cycle valid input -> next cycle out_valid=0, in_ready=1, flags still hold pre-flush values, and the dropped input never appears.
- Reset asserted mid-stream with count=2 and out_ready=0 -> next cycle all outputs at reset values, including flags 0.
